// File: rtl/edge_mem_sched.sv
// Run sequencer for one edge-detection accelerator pass: resets/launches the
// accelerator, arbitrates the shared image memory and records the run length.
module edge_mem_sched #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 120000,
  parameter int CNT_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ready,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  input  logic              h_start,
  input  logic              h_clear,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  cycles,
  output logic              acc_rst,
  output logic              acc_start,
  input  logic              acc_finish,
  input  logic              acc_en,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_dataW,
  output logic [DATA_W-1:0] acc_dataR,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataW,
  input  logic [DATA_W-1:0] mem_dataR
);

  // state  | meaning
  // IDLE   | host owns memory, accelerator held in reset
  // ARST   | accelerator reset released, memory unowned, counter cleared
  // LAUNCH | one-cycle acc_start pulse, accelerator owns memory
  // RUN    | counting cycles until finish or timeout
  // DONE   | result reported, host owns memory, accelerator re-armed
  typedef enum logic [2:0] {IDLE, ARST, LAUNCH, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [DATA_W-1:0]  h_rdata_q;
  logic               host_own;
  logic               acc_own;

  assign host_own  = (state == IDLE) || (state == DONE);
  assign acc_own   = (state == LAUNCH) || (state == RUN);
  assign h_ready   = host_own;
  assign acc_dataR = mem_dataR;
  // Read data is presented straight from memory on the return cycle, then held.
  assign h_rdata   = h_rvalid ? mem_dataR : h_rdata_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = h_addr;
    mem_dataW = h_wdata;
    if (host_own) begin
      mem_en = h_req;
      mem_we = h_req & h_we;
    end else begin
      mem_addr  = acc_addr;
      mem_dataW = acc_dataW;
      mem_en    = acc_own & acc_en;
      mem_we    = acc_own & acc_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_rvalid  <= 1'b0;
      h_rdata_q <= '0;
    end else begin
      h_rvalid <= host_own & h_req & ~h_we;
      if (h_rvalid) h_rdata_q <= mem_dataR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc_rst   <= 1'b1;
      acc_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cycles    <= '0;
      counter   <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc_rst <= 1'b1;
          if (h_start) begin
            state   <= ARST;
            acc_rst <= 1'b0;
          end
        end
        ARST: begin
          acc_rst   <= 1'b0;
          counter   <= '0;
          acc_start <= 1'b1;
          busy      <= 1'b1;
          state     <= LAUNCH;
        end
        LAUNCH: begin
          acc_start <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (counter != CNT_MAX) counter <= counter + 1'b1;
          // Finish takes priority over a coincident timeout.
          if (acc_finish) begin
            state  <= DONE;
            done   <= 1'b1;
            cycles <= counter;
            busy   <= 1'b0;
          end else if (counter == TO_LAST) begin
            state  <= DONE;
            error  <= 1'b1;
            cycles <= TO_VAL;
            busy   <= 1'b0;
          end
        end
        DONE: begin
          acc_rst <= 1'b1;
          if (h_start) begin
            state   <= ARST;
            done    <= 1'b0;
            error   <= 1'b0;
            acc_rst <= 1'b0;
          end else if (h_clear) begin
            state <= IDLE;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_mem_sched.sv
// Directed bench for edge_mem_sched: host port vector table plus run,
// timeout, reset and restart sequences on two differently-parameterised copies.
module tb_edge_mem_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        h_req = 1'b0, h_we = 1'b0, h_start = 1'b0, h_clear = 1'b0;
  logic [15:0] h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic        acc_finish = 1'b0, acc_en = 1'b0, acc_we = 1'b0;
  logic [15:0] acc_addr = '0;
  logic [31:0] acc_dataW = '0;
  logic        t_start = 1'b0, t_clear = 1'b0, t_finish = 1'b0;

  logic        h_ready, h_rvalid, busy, done, error, acc_rst, acc_start;
  logic [31:0] h_rdata, acc_dataR, mem_dataW;
  logic [19:0] cycles;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_dataR = '0;

  logic        t_h_ready, t_h_rvalid, t_busy, t_done, t_error, t_acc_rst, t_acc_start;
  logic [31:0] t_h_rdata, t_acc_dataR, t_mem_dataW;
  logic [19:0] t_cycles;
  logic        t_mem_en, t_mem_we;
  logic [15:0] t_mem_addr;

  logic [31:0] mem_arr [0:65535];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  edge_mem_sched dut (
    .clk(clk), .reset(reset), .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_ready(h_ready), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .h_start(h_start), .h_clear(h_clear), .busy(busy), .done(done), .error(error),
    .cycles(cycles), .acc_rst(acc_rst), .acc_start(acc_start), .acc_finish(acc_finish),
    .acc_en(acc_en), .acc_we(acc_we), .acc_addr(acc_addr), .acc_dataW(acc_dataW),
    .acc_dataR(acc_dataR), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dataW(mem_dataW), .mem_dataR(mem_dataR)
  );

  edge_mem_sched #(.TIMEOUT(100)) dut_t (
    .clk(clk), .reset(reset), .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_ready(t_h_ready), .h_rdata(t_h_rdata), .h_rvalid(t_h_rvalid),
    .h_start(t_start), .h_clear(t_clear), .busy(t_busy), .done(t_done), .error(t_error),
    .cycles(t_cycles), .acc_rst(t_acc_rst), .acc_start(t_acc_start), .acc_finish(t_finish),
    .acc_en(acc_en), .acc_we(acc_we), .acc_addr(acc_addr), .acc_dataW(acc_dataW),
    .acc_dataR(t_acc_dataR), .mem_en(t_mem_en), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
    .mem_dataW(t_mem_dataW), .mem_dataR(mem_dataR)
  );

  // Synchronous memory: read data valid the cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_dataW;
      else        mem_dataR <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered at a negedge in IDLE or DONE; leaves at the negedge of RUN cycle 0.
  task automatic start_main(input logic clr, input logic [15:0] wr_addr, input logic [31:0] wr_data);
    h_start = 1'b1; h_clear = clr;
    h_req = 1'b1; h_we = 1'b1; h_addr = wr_addr; h_wdata = wr_data;
    acc_en = 1'b1; acc_we = 1'b1; acc_addr = 16'h0200;
    #1;
    chk("start_host_ready", h_ready, 1);
    chk("start_host_mem_we", mem_we, 1);
    chk("start_host_addr", mem_addr, wr_addr);
    @(negedge clk);
    h_start = 1'b0; h_clear = 1'b0; h_req = 1'b0; h_we = 1'b0;
    #1;
    chk("arst_mem_en", mem_en, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_acc_rst", acc_rst, 0);
    chk("arst_h_ready", h_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_acc_start", acc_start, 0);
    @(negedge clk);
    #1;
    chk("launch_acc_start", acc_start, 1);
    chk("launch_busy", busy, 1);
    chk("launch_mem_en", mem_en, 1);
    chk("launch_acc_rst", acc_rst, 0);
    @(negedge clk);
    #1;
    chk("run_acc_start", acc_start, 0);
    chk("run_busy", busy, 1);
  endtask

  // Runs RUN cycles 0..fin_k with finish asserted on cycle fin_k; ends in DONE.
  task automatic run_main(input int fin_k);
    for (int k = 0; k <= fin_k; k++) begin
      acc_finish = (k == fin_k);
      acc_en = 1'b1; acc_we = k[0]; acc_addr = 16'h0100 + k[15:0]; acc_dataW = 32'(k) ^ 32'h5A5A0000;
      h_req = (k < 4); h_we = 1'b0; h_addr = 16'h0010;
      #1;
      if (k < 4) begin
        chk("run_h_ready", h_ready, 0);
        chk("run_mem_addr", mem_addr, acc_addr);
        chk("run_mem_we", mem_we, acc_we);
        chk("run_mem_dataW", mem_dataW, acc_dataW);
        chk("run_h_rvalid", h_rvalid, 0);
      end
      @(negedge clk);
    end
    acc_finish = 1'b0; acc_en = 1'b0; acc_we = 1'b0; h_req = 1'b0;
  endtask

  // Entered at negedge; leaves at the negedge of t_dut RUN cycle 0.
  task automatic start_t();
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    #1 chk("t_arst_acc_rst", t_acc_rst, 0);
    @(negedge clk);
    #1 chk("t_launch_acc_start", t_acc_start, 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        x_rvalid;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vt[1] = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[2] = '{1'b0, 1'b0, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b1, 16'h0020, 32'h12345678, 1'b0, 32'hDEADBEEF};
    vt[4] = '{1'b1, 1'b0, 16'h0020, 32'h0,        1'b1, 32'h12345678};
    vt[5] = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[6] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 32'hDEADBEEF};
    vt[7] = '{1'b1, 1'b1, 16'h0010, 32'h000000A5, 1'b0, 32'hDEADBEEF};
    vt[8] = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b1, 32'h000000A5};

    repeat (2) @(negedge clk);
    chk("rst_acc_rst", acc_rst, 1);
    chk("rst_cycles", cycles, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_h_rdata", h_rdata, 0);
    chk("rst_h_ready", h_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      h_req = vt[i].req; h_we = vt[i].we; h_addr = vt[i].addr; h_wdata = vt[i].wdata;
      #1;
      chk("vec_h_ready", h_ready, 1);
      chk("vec_mem_en", mem_en, vt[i].req);
      chk("vec_mem_we", mem_we, vt[i].req & vt[i].we);
      chk("vec_mem_addr", mem_addr, vt[i].addr);
      chk("vec_mem_dataW", mem_dataW, vt[i].wdata);
      @(negedge clk);
      chk("vec_h_rvalid", h_rvalid, vt[i].x_rvalid);
      chk("vec_h_rdata", h_rdata, vt[i].x_rdata);
    end
    h_req = 1'b0;

    // Normal run finishing after 5000 RUN cycles.
    start_main(1'b0, 16'h0030, 32'hCAFE0030);
    run_main(5000);
    #1;
    chk("done_done", done, 1);
    chk("done_error", error, 0);
    chk("done_cycles", cycles, 5000);
    chk("done_busy", busy, 0);
    chk("done_acc_rst_entry", acc_rst, 0);
    chk("done_h_ready", h_ready, 1);
    @(negedge clk);
    #1 chk("done_acc_rst_rearm", acc_rst, 1);
    chk("acc_dataR_passthru", acc_dataR, mem_dataR);

    // Start and clear together in DONE: start wins.
    start_main(1'b1, 16'h0040, 32'hCAFE0040);
    run_main(20);
    #1 chk("restart_cycles", cycles, 20);
    h_clear = 1'b1;
    @(negedge clk);
    h_clear = 1'b0;
    #1;
    chk("clear_done", done, 0);
    chk("clear_acc_rst", acc_rst, 1);
    chk("clear_cycles_hold", cycles, 20);
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0030;
    @(negedge clk);
    h_req = 1'b0;
    chk("start_cycle_write_rvalid", h_rvalid, 1);
    chk("start_cycle_write_data", h_rdata, 32'hCAFE0030);

    // Reset in the middle of a run.
    start_main(1'b0, 16'h0050, 32'hCAFE0050);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_acc_rst", acc_rst, 1);
    chk("midrst_h_ready", h_ready, 1);
    chk("midrst_cycles", cycles, 0);
    @(negedge clk);
    reset = 1'b0;
    start_main(1'b0, 16'h0060, 32'hCAFE0060);
    run_main(10);
    #1;
    chk("postrst_done", done, 1);
    chk("postrst_cycles", cycles, 10);
    h_clear = 1'b1;
    @(negedge clk);
    h_clear = 1'b0;

    // Accepted read cut off by reset returns no h_rvalid.
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0010;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rst_outstanding_rvalid", h_rvalid, 0);
    h_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Timeout on the TIMEOUT=100 copy.
    start_t();
    repeat (99) @(negedge clk);
    acc_en = 1'b1; acc_we = 1'b1; acc_addr = 16'h0123; acc_dataW = 32'h0BADF00D;
    #1;
    chk("to_last_busy", t_busy, 1);
    chk("to_last_error", t_error, 0);
    chk("to_mem_addr", t_mem_addr, 16'h0123);
    chk("to_mem_we", t_mem_we, 1);
    chk("to_mem_en", t_mem_en, 1);
    chk("to_mem_dataW", t_mem_dataW, 32'h0BADF00D);
    @(negedge clk);
    acc_en = 1'b0; acc_we = 1'b0;
    #1;
    chk("to_error", t_error, 1);
    chk("to_done", t_done, 0);
    chk("to_cycles", t_cycles, 100);
    chk("to_busy", t_busy, 0);
    chk("to_h_ready", t_h_ready, 1);
    chk("to_h_rvalid", t_h_rvalid, 0);
    chk("to_acc_dataR", t_acc_dataR, mem_dataR);
    chk("to_h_rdata", t_h_rdata, 0);
    t_clear = 1'b1;
    @(negedge clk);
    t_clear = 1'b0;
    #1 chk("to_clear_error", t_error, 0);

    // Finish on the same cycle the timeout would fire.
    @(negedge clk);
    start_t();
    repeat (99) @(negedge clk);
    t_finish = 1'b1;
    @(negedge clk);
    t_finish = 1'b0;
    #1;
    chk("edge_done", t_done, 1);
    chk("edge_error", t_error, 0);
    chk("edge_cycles", t_cycles, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
